// File: rtl/tx_stim_pkg.sv
// Shared types and constants for the transmitter-buffer stimulus generator.
package tx_stim_pkg;

    typedef enum logic [1:0] {
        MODE_TABLE = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } tx_stim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tx_stim_state_e;

    localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;

endpackage

// File: rtl/tx_stim_pat_tbl.sv
// Programmable pattern table: register array with a write port that only
// commits while the generator is idle, and an asynchronous read port.
module tx_stim_pat_tbl #(
    parameter int DATA_W    = 8,
    parameter int PAT_DEPTH = 16,
    parameter int AW        = $clog2(PAT_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              idle_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [PAT_DEPTH];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < PAT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && idle_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/tx_stim_gen.sv
// Burst stimulus generator in front of the transmitter buffer load port:
// table / incrementing / LFSR / walking-one words with buffer backpressure.
module tx_stim_gen
    import tx_stim_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                PAT_DEPTH = 16,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [CNT_W-1:0]             burst_len,
    input  logic                         pat_wr_en,
    input  logic [$clog2(PAT_DEPTH)-1:0] pat_wr_addr,
    input  logic [DATA_W-1:0]            pat_wr_data,
    input  logic                         tx_buff_full,
    output logic [DATA_W-1:0]            data_in,
    output logic                         tx_buff_ld,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             sent_count
);

    localparam int AW = $clog2(PAT_DEPTH);

    tx_stim_state_e    state_q, state_d;
    tx_stim_mode_e     mode_q, mode_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] gen_q, gen_d;
    logic [DATA_W-1:0] gen_next;
    logic [DATA_W-1:0] tbl_rd;
    logic              accept;

    tx_stim_pat_tbl #(
        .DATA_W   (DATA_W),
        .PAT_DEPTH(PAT_DEPTH),
        .AW       (AW)
    ) u_pat_tbl (
        .clk_i    (clk),
        .reset_ni (reset),
        .idle_i   (state_q == ST_IDLE),
        .wr_en_i  (pat_wr_en),
        .wr_addr_i(pat_wr_addr),
        .wr_data_i(pat_wr_data),
        .rd_addr_i(idx_q),
        .rd_data_o(tbl_rd)
    );

    // Load handshake: tx_buff_ld is valid, !tx_buff_full is ready; a word
    // transfers on any cycle where both hold, otherwise data_in stays put.
    assign tx_buff_ld = (state_q == ST_RUN);
    assign accept     = tx_buff_ld && !tx_buff_full;
    assign busy       = tx_buff_ld;
    assign done       = (state_q == ST_DONE);
    assign sent_count = cnt_q;
    assign data_in    = !tx_buff_ld ? '0 : (mode_q == MODE_TABLE) ? tbl_rd : gen_q;

    always_comb begin
        gen_next = gen_q;
        case (mode_q)
            MODE_INCR: gen_next = gen_q + DATA_W'(1);
            MODE_LFSR: gen_next = (gen_q >> 1) ^ (gen_q[0] ? LFSR_TAPS : '0);
            MODE_WALK: gen_next = {gen_q[DATA_W-2:0], gen_q[DATA_W-1]};
            default:   gen_next = gen_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        gen_d   = gen_q;
        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    state_d = ST_RUN;
                    mode_d  = tx_stim_mode_e'(mode);
                    len_d   = burst_len;
                    cnt_d   = '0;
                    idx_d   = '0;
                    gen_d   = (mode == MODE_INCR) ? '0 : DATA_W'(1);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    idx_d = idx_q + AW'(1);
                    gen_d = gen_next;
                end
                // A word accepted on the abort edge still counts; done is
                // only reachable with enable held high.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (accept && (len_q != '0) && (cnt_d == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_TABLE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gen_q   <= gen_d;
        end
    end

endmodule

// File: tb/tb_tx_stim_gen.sv
// Randomized bench for tx_stim_gen: expected words come from a per-index
// reference (word number k of each mode) queued into exp_q per burst.
module tb_tx_stim_gen;

    localparam int DATA_W    = 8;
    localparam int PAT_DEPTH = 16;
    localparam int CNT_W     = 16;
    localparam int AW        = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              start;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  burst_len;
    logic              pat_wr_en;
    logic [AW-1:0]     pat_wr_addr;
    logic [DATA_W-1:0] pat_wr_data;
    logic              tx_buff_full;
    logic [DATA_W-1:0] data_in;
    logic              tx_buff_ld;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_count;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] tbl_m [PAT_DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    tx_stim_gen #(
        .DATA_W   (DATA_W),
        .PAT_DEPTH(PAT_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .mode        (mode),
        .burst_len   (burst_len),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .tx_buff_full(tx_buff_full),
        .data_in     (data_in),
        .tx_buff_ld  (tx_buff_ld),
        .busy        (busy),
        .done        (done),
        .sent_count  (sent_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word number k of a burst, straight from the mode definitions.
    function automatic logic [DATA_W-1:0] word_at(input int m, input int k);
        logic [DATA_W-1:0] v;
        case (m)
            0: return tbl_m[k % PAT_DEPTH];
            1: return DATA_W'(k % 256);
            2: begin
                v = 8'h01;
                for (int i = 0; i < k; i++) begin
                    v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
                end
                return v;
            end
            default: return DATA_W'(1 << (k % 8));
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tbl_write(input int a, input logic [DATA_W-1:0] d);
        pat_wr_en   = 1'b1;
        pat_wr_addr = AW'(a);
        pat_wr_data = d;
        step();
        pat_wr_en   = 1'b0;
        tbl_m[a]    = d;
    endtask

    task automatic run_burst(input int m, input int len, input int full_pct, input int hold_first,
                             input bit wr_with_start, input bit wr_in_run);
        int acc;
        int budget;
        int iter;
        exp_q.delete();
        if (wr_with_start) begin
            pat_wr_en   = 1'b1;
            pat_wr_addr = '0;
            pat_wr_data = DATA_W'($urandom);
            tbl_m[0]    = pat_wr_data;
        end
        for (int k = 0; k < len; k++) exp_q.push_back(word_at(m, k));
        mode         = 2'(m);
        burst_len    = CNT_W'(len);
        start        = 1'b1;
        tx_buff_full = 1'b0;
        step();
        start     = 1'b0;
        pat_wr_en = 1'b0;
        mode      = 2'($urandom);
        burst_len = CNT_W'($urandom);
        acc    = 0;
        iter   = 0;
        budget = len * 10 + 100;
        while (acc < len && budget > 0) begin
            check("busy_run", busy, 1);
            check("ld_run", tx_buff_ld, 1);
            check("cnt_run", sent_count, acc);
            check("data", data_in, exp_q[0]);
            check("done_run", done, 0);
            pat_wr_en = 1'b0;
            if (wr_in_run) begin
                pat_wr_en   = 1'b1;
                pat_wr_addr = AW'($urandom);
                pat_wr_data = DATA_W'($urandom);
            end
            tx_buff_full = (iter < hold_first) || ($urandom_range(99) < full_pct);
            if (!tx_buff_full) begin
                void'(exp_q.pop_front());
                acc++;
            end
            iter++;
            step();
            budget--;
        end
        check("burst_words", acc, len);
        tx_buff_full = 1'b0;
        pat_wr_en    = 1'b0;
        check("done_pulse", done, 1);
        check("ld_after", tx_buff_ld, 0);
        check("busy_done", busy, 0);
        check("cnt_final", sent_count, len);
        step();
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("cnt_hold", sent_count, len);
    endtask

    task automatic run_cont(input int m, input int cycles, input int full_pct);
        int acc;
        mode         = 2'(m);
        burst_len    = '0;
        start        = 1'b1;
        tx_buff_full = 1'b0;
        step();
        start = 1'b0;
        acc   = 0;
        for (int i = 0; i < cycles; i++) begin
            check("busy_cont", busy, 1);
            check("ld_cont", tx_buff_ld, 1);
            check("data_cont", data_in, word_at(m, acc));
            check("cnt_cont", sent_count, acc);
            check("done_cont", done, 0);
            tx_buff_full = ($urandom_range(99) < full_pct);
            if (i == cycles - 1) enable = 1'b0;
            if (!tx_buff_full) acc++;
            step();
        end
        tx_buff_full = 1'b0;
        check("ld_abort", tx_buff_ld, 0);
        check("busy_abort", busy, 0);
        check("done_abort", done, 0);
        check("cnt_abort", sent_count, acc);
        enable = 1'b1;
        step();
        check("done_abort2", done, 0);
        check("cnt_abort2", sent_count, acc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; enable = 1'b0; start = 1'b0; mode = '0; burst_len = '0;
        pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0; tx_buff_full = 1'b0;
        for (int i = 0; i < PAT_DEPTH; i++) tbl_m[i] = '0;
        #1;
        check("rst_data", data_in, 0);
        check("rst_ld", tx_buff_ld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sent_count, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // start with enable low is ignored
        start = 1'b1;
        mode  = 2'd1;
        burst_len = 16'd4;
        step();
        start = 1'b0;
        check("ign_busy", busy, 0);
        check("ign_ld", tx_buff_ld, 0);
        step();
        check("ign_busy2", busy, 0);
        enable = 1'b1;

        // directed table / backpressure / LFSR / WALK bursts
        tbl_write(0, 8'hAA);
        tbl_write(1, 8'h55);
        tbl_write(2, 8'hCC);
        run_burst(0, 3, 0, 0, 1'b0, 1'b0);
        run_burst(1, 4, 0, 3, 1'b0, 1'b0);
        run_burst(2, 3, 0, 0, 1'b0, 1'b0);
        run_burst(3, 9, 0, 0, 1'b0, 1'b0);

        // table wrap with ignored writes during the burst, INCR wrap
        for (int i = 0; i < PAT_DEPTH; i++) tbl_write(i, DATA_W'($urandom));
        run_burst(0, 18, 0, 0, 1'b0, 1'b1);
        run_burst(0, 18, 0, 0, 1'b0, 1'b0);
        run_burst(1, 257, 0, 0, 1'b0, 1'b0);

        // write in the same cycle as start reaches the first word
        run_burst(0, 2, 20, 0, 1'b1, 1'b0);

        // continuous run then abort
        run_cont(2, 40, 30);
        run_cont(1, 25, 0);

        // randomized bursts
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(1) == 1) tbl_write($urandom_range(PAT_DEPTH - 1), DATA_W'($urandom));
            run_burst($urandom_range(3), $urandom_range(20, 1), $urandom_range(50), 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // asynchronous reset in the middle of a burst
        mode = 2'd1; burst_len = '0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_ld", tx_buff_ld, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", data_in, 0);
        check("arst_ld", tx_buff_ld, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cnt", sent_count, 0);
        for (int i = 0; i < PAT_DEPTH; i++) tbl_m[i] = '0;
        step();
        reset = 1'b1;
        step();
        run_burst(0, 4, 0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_stim_gen.md
Name: tx_stim_gen

Overview:
Parametrised stimulus generator that drives the transmitter buffer's data_in / tx_buff_ld load interface. It supersedes the fixed-pattern driver with four generation modes, programmable pattern table, burst length and backpressure from the buffer. It sits in the bench/system wrapper directly in front of the transmitter buffer load port.

Parameters:
DATA_W, 8, width of data_in and pattern table entries
PAT_DEPTH, 16, number of pattern table entries (power of two, >=2)
CNT_W, 16, width of burst_len and sent_count
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (DATA_W bits)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  global run enable; low aborts a burst
start  in  1  single-cycle pulse, begins a burst when in IDLE
mode  in  2  0=TABLE, 1=INCR, 2=LFSR, 3=WALK; sampled on start
burst_len  in  CNT_W  words per burst; 0 = continuous; sampled on start
pat_wr_en  in  1  pattern table write strobe
pat_wr_addr  in  $clog2(PAT_DEPTH)  table write index
pat_wr_data  in  DATA_W  table write data
tx_buff_full  in  1  backpressure from transmitter buffer
data_in  out  DATA_W  word offered to buffer
tx_buff_ld  out  1  data_in valid / load request
busy  out  1  high while in RUN
done  out  1  one-cycle pulse after last word of finite burst accepted
sent_count  out  CNT_W  words accepted in current/last burst

Behaviour:
- Reset (reset=0, async): data_in=0, tx_buff_ld=0, busy=0, done=0, sent_count=0, FSM=IDLE, all table entries=0, generator state cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 and enable=1 -> RUN next cycle; latch mode and burst_len; clear sent_count; load generator seed. start while enable=0 ignored.
- RUN: busy=1, tx_buff_ld=1 from the first RUN cycle (one-cycle latency after start) with the first word on data_in.
- Accept: a word is transferred on a cycle with tx_buff_ld=1 and tx_buff_full=0; next cycle data_in advances to the next word and sent_count increments (saturates at all-ones).
- Hold: while tx_buff_full=1, data_in and tx_buff_ld held stable.
- Finite burst: on the accept that makes sent_count==burst_len -> DONE; tx_buff_ld=0 that next cycle.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. sent_count retains final value until next start.
- burst_len=0: RUN indefinitely; no done; exit only via enable=0.
- Abort: enable=0 in RUN -> IDLE next cycle, tx_buff_ld=0 (only permitted drop of an unaccepted word), done not pulsed, sent_count retained.
- start, mode and burst_len changes during RUN/DONE ignored.
- Generation, first word / next word:
  - TABLE: table[0]; index+1, wraps PAT_DEPTH-1 -> 0.
  - INCR: 0; +1 modulo 2^DATA_W (all-ones -> 0).
  - LFSR: 1; Galois shift right, XOR LFSR_TAPS when shifted-out bit=1; never reaches 0.
  - WALK: 1; rotate left by 1, MSB wraps to bit 0.
- Table writes accepted only in IDLE; writes in RUN/DONE ignored. Write and start in same cycle: write takes effect, first word reads the new value if the address is 0.

Decomposition:
- Package tx_stim_pkg: mode enum (TABLE, INCR, LFSR, WALK), FSM state enum, default LFSR_TAPS constant.
- Sub-module tx_stim_pat_tbl: PAT_DEPTH x DATA_W register table with async reset, IDLE-gated write port and combinational read port.
- The FSM, generators and counters stay in tx_stim_gen.

Test Plan:
- TABLE burst: write table[0..2]=AA,55,CC, mode=0, burst_len=3, full=0, start -> data_in AA,55,CC on 3 consecutive cycles, done one cycle after, sent_count=3.
- Backpressure: mode=1, burst_len=4, full=1 for 3 cycles after first word -> data_in=00 held stable with tx_buff_ld=1; then 00,01,02,03 accepted, done pulse.
- LFSR/WALK: mode=2 burst_len=3 -> 01,B8,5C; mode=3 burst_len=9 -> 01,02,...,80,01.
- Wrap: mode=0, burst_len=18, PAT_DEPTH=16 -> words 17,18 equal table[0],table[1]; mode=1 starting run of 257 ends with FF,00.
- Continuous/abort: burst_len=0, run 40 cycles then enable=0 -> tx_buff_ld=0 next cycle, no done, sent_count=accepted count; start with enable=0 ignored.
- Reset mid-burst and ignored writes: pat_wr_en in RUN leaves table unchanged; reset low mid-RUN -> all outputs 0 immediately (async), table cleared, IDLE.
